// File: rtl/uart_tx_mmio.sv
// -----------------------------------------------------------------------------
// uart_tx_mmio
//
// Memory-mapped 8N1 UART transmitter. Software loads a byte into the TXD
// register, writes CON with bit0=1 to launch a frame, polls CON bit2
// (tx_done) and clears CON by writing 0.
//
// Register map (addr[1:0] ignored):
//   TXD_ADDR : {24'b0, txd}
//   CON_ADDR : {27'b0, busy, 1'b0, tx_done, 1'b0, tx_en}
//
// Ports:
//   clk      in   1  system clock, all state on rising edge
//   reset    in   1  synchronous, active-high reset
//   addr     in  32  bus byte address
//   wdata    in  32  bus write data
//   wr_en    in   1  bus write strobe, one cycle per store
//   rdata    out 32  combinational read data (pure register decode)
//   tx       out  1  registered serial output, idle high
//   tx_busy  out  1  high while a frame is in flight
// -----------------------------------------------------------------------------
module uart_tx_mmio #(
    parameter int          CLK_FREQ = 50000000,
    parameter int          BAUD     = 9600,
    parameter logic [31:0] TXD_ADDR = 32'h4000_0018,
    parameter logic [31:0] CON_ADDR = 32'h4000_0020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wr_en,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        tx_busy
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           state_q,    state_d;
    logic [7:0]       txd_q,      txd_d;
    logic [7:0]       shift_q,    shift_d;
    logic             tx_en_q,    tx_en_d;
    logic             tx_done_q,  tx_done_d;
    logic             busy_q,     busy_d;
    logic             tx_q,       tx_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q,  bit_idx_d;

    // Word-granular decode: the low two address bits select a byte lane only.
    logic txd_sel, con_sel, txd_wr, con_wr, bit_end, start_trig;

    assign txd_sel    = (addr[31:2] == TXD_ADDR[31:2]);
    assign con_sel    = (addr[31:2] == CON_ADDR[31:2]);
    assign txd_wr     = wr_en && txd_sel;
    assign con_wr     = wr_en && con_sel;
    assign bit_end    = (baud_cnt_q == CNT_MAX);
    // Edge-style launch: only the CON write itself starts a frame, so a
    // tx_en left at 1 never causes a retransmit.
    assign start_trig = con_wr && wdata[0] && (state_q == S_IDLE);

    // Upper write-data bits and the byte-lane address bits carry no state.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{wdata[31:8], addr[1:0]};

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        txd_d      = txd_q;
        shift_d    = shift_q;
        tx_en_d    = tx_en_q;
        tx_done_d  = tx_done_q;
        busy_d     = busy_q;
        tx_d       = tx_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;

        // TXD only accepts new data between frames.
        if (txd_wr && !busy_q) begin
            txd_d = wdata[7:0];
        end

        if (con_wr) begin
            tx_en_d   = wdata[0];
            tx_done_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                tx_d       = 1'b1;
                baud_cnt_d = '0;
                if (start_trig) begin
                    // Shadow copy decouples the wire from later TXD writes.
                    shift_d    = txd_q;
                    state_d    = S_START;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    bit_idx_d  = 3'd0;
                end
            end

            S_START: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = 3'd0;
                    state_d    = S_DATA;
                    tx_d       = shift_q[0];
                    shift_d    = {1'b0, shift_q[7:1]};
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // shift_q[0] already holds the next LSB-first bit.
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    state_d    = S_IDLE;
                    busy_d     = 1'b0;
                    tx_d       = 1'b1;
                    // Placed after the CON-write clear so completion wins.
                    tx_done_d  = 1'b1;
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q    <= S_IDLE;
            txd_q      <= 8'h00;
            shift_q    <= 8'h00;
            tx_en_q    <= 1'b0;
            tx_done_q  <= 1'b0;
            busy_q     <= 1'b0;
            tx_q       <= 1'b1;
            baud_cnt_q <= '0;
            bit_idx_q  <= 3'd0;
        end else begin
            state_q    <= state_d;
            txd_q      <= txd_d;
            shift_q    <= shift_d;
            tx_en_q    <= tx_en_d;
            tx_done_q  <= tx_done_d;
            busy_q     <= busy_d;
            tx_q       <= tx_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (txd_sel) begin
            rdata = {24'h0, txd_q};
        end else if (con_sel) begin
            rdata = {27'h0, busy_q, 1'b0, tx_done_q, 1'b0, tx_en_q};
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_mmio
//
// Scoreboard bench for uart_tx_mmio with CLK_FREQ=16, BAUD=1 (16 clocks/bit).
// Stimulus pushes cycle-stamped expectations into a sorted queue; a monitor
// on the falling edge pops every entry due in the current cycle and compares
// it against tx, tx_busy or rdata.
// -----------------------------------------------------------------------------
module tb_uart_tx_mmio;

    localparam logic [31:0] TXD_A = 32'h4000_0018;
    localparam logic [31:0] CON_A = 32'h4000_0020;
    localparam int          FRAME = 160;

    // Hand-computed 10-slot line patterns, slot 0 (start bit) is bit 9.
    localparam logic [9:0] PAT_A5 = 10'b0101001011;
    localparam logic [9:0] PAT_3C = 10'b0001111001;
    localparam logic [9:0] PAT_55 = 10'b0101010101;
    localparam logic [9:0] PAT_00 = 10'b0000000001;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr_en;
    logic [31:0] rdata;
    logic        tx;
    logic        tx_busy;

    always #5 clk = ~clk;

    uart_tx_mmio #(
        .CLK_FREQ(16),
        .BAUD    (1),
        .TXD_ADDR(TXD_A),
        .CON_ADDR(CON_A)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .wdata  (wdata),
        .wr_en  (wr_en),
        .rdata  (rdata),
        .tx     (tx),
        .tx_busy(tx_busy)
    );

    typedef enum {K_TX, K_BUSY, K_RDATA} kind_t;
    typedef struct {
        int          cyc;
        kind_t       kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Sorted insert keeps the queue ordered by due cycle.
    function automatic void push(input int c, input kind_t k,
                                 input logic [31:0] e, input string n);
        exp_t it;
        int   i;
        it.cyc  = c;
        it.kind = k;
        it.exp  = e;
        it.name = n;
        i = sb.size();
        while (i > 0 && sb[i-1].cyc > c) i--;
        sb.insert(i, it);
    endfunction

    // Monitor: compares everything due this cycle, flags anything overdue.
    always @(negedge clk) begin
        exp_t        it;
        logic [31:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            it = sb.pop_front();
            checks++;
            if (it.cyc < cyc) begin
                errors++;
                $display("FAIL %s: check due at cycle %0d missed (now %0d)",
                         it.name, it.cyc, cyc);
            end else begin
                case (it.kind)
                    K_TX:    act = {31'h0, tx};
                    K_BUSY:  act = {31'h0, tx_busy};
                    default: act = rdata;
                endcase
                if (act !== it.exp) begin
                    errors++;
                    $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h",
                             it.name, cyc, act, it.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
        addr = a;
        push(cyc, K_RDATA, e, n);
        tick();
        addr = 32'h0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push_idle(input int c, input int n, input string nm);
        for (int i = 0; i < n; i++) push(c + i, K_TX, 32'h1, nm);
    endtask

    task automatic push_frame(input int s, input logic [9:0] pat,
                              input int ncyc, input string nm);
        logic [9:0] p;
        p = pat;
        for (int i = 0; i < ncyc; i++) begin
            push(s + i, K_TX,   {31'h0, p[9 - i/16]}, nm);
            push(s + i, K_BUSY, 32'h1, {nm, "_busy"});
        end
    endtask

    // Loads TXD, queues the expected line/busy behaviour, then writes CON=1.
    // s returns the first start-bit cycle (the cycle after the CON write).
    task automatic start_frame(input logic [7:0] b, input logic [9:0] pat,
                               input int ncyc, input string nm, output int s);
        wr(TXD_A, {24'h0, b});
        s = cyc + 1;
        push(cyc, K_BUSY, 32'h0, {nm, "_busy_before"});
        push_frame(s, pat, ncyc, nm);
        wr(CON_A, 32'h1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r;
        int s;

        reset = 1'b1;
        addr  = 32'h0;
        wdata = 32'h0;
        wr_en = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state and a long idle line.
        r = cyc;
        push_idle(r, 100, "idle_after_reset");
        push(r, K_BUSY, 32'h0, "busy_after_reset");
        rd(CON_A, 32'h0, "con_reset");
        rd(TXD_A, 32'h0, "txd_reset");
        wr(32'h4000_0010, 32'hFF);
        rd(TXD_A | 32'h2, 32'h0, "txd_other_addr_write");
        wait_until(r + 100);

        // 0xA5 frame, done timing, no retransmit with tx_en held.
        start_frame(8'hA5, PAT_A5, FRAME, "frame_a5", s);
        push(s + FRAME, K_BUSY, 32'h0, "a5_busy_end");
        push_idle(s + FRAME, 60, "a5_no_retransmit");
        wait_until(s + FRAME - 1);
        rd(CON_A, 32'h11, "a5_con_last_stop");
        rd(CON_A, 32'h05, "a5_con_done");
        rd(TXD_A, 32'hA5, "a5_txd");
        wait_until(s + FRAME + 60);
        wr(CON_A, 32'h0);
        rd(CON_A, 32'h0, "con_cleared");

        // 0x3C frame with TXD and CON writes while busy.
        start_frame(8'h3C, PAT_3C, FRAME, "frame_3c", s);
        wait_until(s + 40);
        wr(TXD_A, 32'hFF);
        wr(CON_A, 32'h1);
        push(s + FRAME, K_BUSY, 32'h0, "3c_busy_end");
        push_idle(s + FRAME, 100, "3c_no_second_frame");
        wait_until(s + FRAME);
        rd(CON_A, 32'h05, "3c_con_done");
        rd(TXD_A, 32'h3C, "3c_txd_kept");
        wait_until(s + FRAME + 100);

        // CON write on the final STOP clock: completion must win.
        wr(CON_A, 32'h0);
        start_frame(8'h3C, PAT_3C, FRAME, "frame_done_race", s);
        wait_until(s + FRAME - 1);
        wr(CON_A, 32'h0);
        rd(CON_A, 32'h04, "done_wins_over_con_write");
        wr(CON_A, 32'h0);

        // Reset in DATA bit 3 of 0x00, then a clean 0x55 frame.
        start_frame(8'h00, PAT_00, 71, "frame_00_partial", s);
        wait_until(s + 70);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        push_idle(cyc, 20, "tx_after_mid_reset");
        push(cyc, K_BUSY, 32'h0, "busy_after_mid_reset");
        rd(CON_A, 32'h0, "con_after_mid_reset");
        rd(TXD_A, 32'h0, "txd_after_mid_reset");
        wait_until(s + 100);

        start_frame(8'h55, PAT_55, FRAME, "frame_55", s);
        push(s + FRAME, K_BUSY, 32'h0, "55_busy_end");
        push_idle(s + FRAME, 20, "55_idle_after");
        wait_until(s + FRAME);
        rd(CON_A, 32'h05, "55_con_done");
        wait_until(s + FRAME + 20);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
        while (sb.size() > 0) begin
            exp_t it;
            it = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: check due at cycle %0d never evaluated",
                     it.name, it.cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the CPU data bus. It is the transmit end of the serial link the instruction program drives.
- Software writes a byte to UART_TXD (0x40000018), then writes UART_CON (0x40000020) with bit0=1 to start. It then polls UART_CON bit2 (TX done) and clears CON with a write of 0.
- The block sits beside data memory in the peripheral address decode. It serialises 8N1 frames onto the tx pin.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate; DIV = CLK_FREQ/BAUD clocks per bit (integer divide, DIV >= 2 required).
- TXD_ADDR, 32'h4000_0018, byte address of the TXD register.
- CON_ADDR, 32'h4000_0020, byte address of the CON register.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  bus byte address; bits [1:0] ignored.
- wdata  in  32  bus write data.
- wr_en  in  1  bus write strobe, one cycle per store.
- rdata  out  32  combinational read data:
  - TXD_ADDR -> {24'b0, txd}
  - CON_ADDR -> {27'b0, busy, 1'b0, tx_done, 1'b0, tx_en}
  - otherwise 0
- tx  out  1  serial output, idle high.
- tx_busy  out  1  high while a frame is in flight.

Behaviour:
- Reset values: txd=8'h00, tx_en=0, tx_done=0, busy=0, tx=1, state=IDLE, baud counter=0, bit index=0.
- TXD write (wr_en, addr==TXD_ADDR):
  - If not busy, txd<=wdata[7:0] at the clock edge.
  - If busy, the write is ignored; txd stays unchanged.
- CON write (wr_en, addr==CON_ADDR):
  - tx_en<=wdata[0].
  - tx_done<=0, unless a frame completes in the same cycle; completion wins and tx_done ends at 1.
  - If wdata[0]==1 and state==IDLE, a frame start is triggered.
  - If wdata[0]==1 while busy, no new start; tx_en is still updated.
- Start is write-triggered, not level-triggered: tx_en held at 1 after a frame never retransmits.
- The frame shifts from a shadow register captured from txd at the start trigger. A later TXD write cannot corrupt an in-flight frame.
- FSM: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE:
  - tx=1, busy=0.
  - On start trigger: capture shadow, go to START, busy=1 from the next cycle.
- START:
  - tx=0 for exactly DIV clocks.
  - The first tx=0 cycle is the cycle after the CON write edge.
- DATA:
  - 8 bits, LSB first, each held DIV clocks.
  - The bit index counts 0..7; after bit 7 go to STOP.
- STOP:
  - tx=1 for DIV clocks.
  - On the last clock: tx_done<=1, busy<=0, state<=IDLE.
- Frame length is exactly 10*DIV clocks from the first start-bit cycle to the tx_done rise.
- Baud counter:
  - Counts 0..DIV-1 and wraps to 0 on each bit boundary.
  - Clears to 0 on entering START.
  - Counter width is $clog2(DIV).
- tx is registered: no glitches, no combinational path from the bus.
- tx_busy equals the busy flag.
- tx_done is sticky until a CON write or reset.
- Reset mid-frame: on the next edge tx=1, IDLE, all flags cleared; the partial frame is abandoned.
- Writes to other addresses have no effect.
- rdata is a pure decode of the current register state.

Test Plan (CLK_FREQ=16, BAUD=1, so DIV=16):
- Reset, then read CON and TXD -> both 0; tx=1 for 100 cycles.
- Write TXD=0xA5, then CON=1:
  - tx sequence per 16-clock slot is 0,1,0,1,0,0,1,0,1,1.
  - CON read returns 0x05 exactly 160 cycles after the first start-bit cycle.
  - busy=1 throughout the frame.
- After completion, write CON=0 -> CON reads 0x00.
- With tx_en still 1 and no new CON write, tx stays 1 -> no retransmit.
- During a frame of 0x3C, write TXD=0xFF and CON=1:
  - The 0x3C frame completes unchanged.
  - TXD still reads 0x3C.
  - No second frame is sent.
- Write a CON value on the exact final STOP clock -> CON reads tx_done=1 after the edge (completion wins).
- Assert reset at DATA bit 3 of 0x00:
  - Next cycle tx=1, busy=0, tx_done=0.
  - A subsequent TXD=0x55 plus CON=1 sends a clean full frame.
